// File: rtl/fpu_pkg.sv
// fpu_pkg: shared single-precision constants and field helpers for the
// FPU integer/float converters.
//   BIAS, EXP_W, MAN_W : IEEE-754 single exponent bias and field widths
//   FP_ZERO            : +0.0 encoding
//   FP_NEG_2P31        : -2^31, the only negative power of two whose
//                        magnitude needs all 32 integer bits
//   fp_sign/fp_exp/fp_man : slice a packed single into its fields
package fpu_pkg;

  localparam int BIAS  = 127;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_2P31 = 32'hCF00_0000;

  function automatic logic fp_sign(input logic [31:0] w);
    return w[31];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] w);
    return w[30 -: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(input logic [31:0] w);
    return w[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/lzc32.sv
// lzc32: combinational 32-bit leading-zero counter.
//   a    : operand
//   cnt  : number of zeros above the most significant set bit (0..31);
//          reads 0 when a is all zero, so qualify with zero
//   zero : a == 0
module lzc32 (
  input  logic [31:0] a,
  output logic [4:0]  cnt,
  output logic        zero
);

  // Ascending scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) cnt = 5'(31 - i);
    end
  end

  assign zero = (a == 32'd0);

endmodule

// File: rtl/i2fp_pipe.sv
// i2fp_pipe: 32-bit integer (signed or unsigned per transaction) to
// IEEE-754 single, three register stages with valid/ready on both sides.
//   clk, rst               : clock, async active-high reset
//   in_valid/in_ready      : input handshake; in_ready = out_ready | ~out_valid
//   in_num, in_unsigned    : operand and its interpretation
//   out_valid/out_ready    : output handshake
//   out_num, out_inexact   : result, and flag for discarded nonzero bits
// One global advance enable moves every stage together, so a stall
// freezes the whole pipe and empty slots are simply overwritten.
// Build option: define I2FP_ROUND_NEAREST_EN for round-to-nearest-even in
// the last stage; without it the result is truncated toward zero.
module i2fp_pipe
  import fpu_pkg::*;
#(
  parameter int BIAS  = fpu_pkg::BIAS,
  parameter int EXP_W = fpu_pkg::EXP_W,
  parameter int MAN_W = fpu_pkg::MAN_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_num,
  input  logic        in_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_num,
  output logic        out_inexact
);

  localparam int BODY_W = EXP_W + MAN_W;  // {exp, frac}, 31 bits

  typedef struct packed {
    logic        sign;
    logic        zero;
    logic [31:0] mag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [EXP_W-1:0] exp;
    logic [31:0]      norm;
  } s2_t;

  typedef struct packed {
    logic [31:0] num;
    logic        inexact;
  } s3_t;

  logic       adv;
  logic [3:1] vld_pipe_d, vld_pipe_q;
  s1_t        s1_d, s1_q;
  s2_t        s2_d, s2_q;
  s3_t        s3_d, s3_q;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign vld_pipe_d = {vld_pipe_q[2:1], in_valid};

  // S1: sign and magnitude. Negating 0x80000000 wraps to itself, which
  // is exactly the 2^31 magnitude we want.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_num[31] & ~in_unsigned;
    s1_d.mag  = s1_d.sign ? (~in_num + 32'd1) : in_num;
    s1_d.zero = (s1_d.mag == 32'd0);
  end

  // S2: normalize so bit 31 is the hidden one.
  logic [4:0] lz;
  logic       lz_zero;

  lzc32 u_lzc (
    .a    (s1_q.mag),
    .cnt  (lz),
    .zero (lz_zero)
  );

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.zero = s1_q.zero;
    s2_d.norm = s1_q.mag << lz;
    s2_d.exp  = lz_zero ? '0 : EXP_W'(BIAS + 31 - int'(lz));
  end

  // S3: pack. Carry out of the fraction on rounding runs straight into
  // the exponent because {exp, frac} is incremented as one word; the
  // exponent tops out at 159, so it can never reach all-ones.
  logic [MAN_W-1:0]  frac;
  logic              guard;
  logic              sticky;
  logic [BODY_W-1:0] body;

  always_comb begin
    frac   = s2_q.norm[30 -: MAN_W];
    guard  = s2_q.norm[30-MAN_W];
    sticky = |s2_q.norm[29-MAN_W:0];
    body   = {s2_q.exp, frac};
`ifdef I2FP_ROUND_NEAREST_EN
    if (guard & (sticky | frac[0])) body = body + BODY_W'(1);
`endif
    s3_d         = '0;
    s3_d.num     = s2_q.zero ? FP_ZERO : {s2_q.sign, body};
    s3_d.inexact = ~s2_q.zero & (guard | sticky);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
    end else if (adv) begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
    end
  end

  assign out_valid   = vld_pipe_q[3];
  assign out_num     = s3_q.num;
  assign out_inexact = s3_q.inexact;

endmodule
